// File: rtl/l1d_refill_ctrl.sv
// L1D line-fill controller: LFB allocation, single-slot memory issue, beat assembly and line write.
// Optional L1D_REFILL_MERGE_EN: a miss to a line already in flight is accepted without a new entry.
module l1d_refill_ctrl #(
    parameter int OFFSET_BITS = 2,
    parameter int SET_BITS    = 5,
    parameter int ADDR_BITS   = 30,
    parameter int LFB_SZ      = 4,
    localparam int LA         = ADDR_BITS - OFFSET_BITS,
    localparam int TAG_BITS   = LA - SET_BITS,
    localparam int ID         = $clog2(LFB_SZ),
    localparam int WORDS      = 2**OFFSET_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [LA-1:0]         miss_addr,
    input  logic [LA-1:0]         lookup_addr,
    output logic                  pending_hit,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [LA-1:0]         mem_req_addr,
    output logic [ID-1:0]         mem_req_id,
    input  logic                  mem_resp_valid,
    input  logic [ID-1:0]         mem_resp_id,
    input  logic [31:0]           mem_resp_data,
    input  logic                  mem_resp_last,
    output logic                  fill_en,
    output logic [SET_BITS-1:0]   fill_set,
    output logic [TAG_BITS-1:0]   fill_tag,
    output logic [32*WORDS-1:0]   fill_line,
    output logic                  err
);

    typedef enum logic [1:0] {E_FREE, E_WAIT_ISSUE, E_WAIT_RESP, E_FILL} ent_state_t;

    ent_state_t              state_q [LFB_SZ];
    ent_state_t              state_d [LFB_SZ];
    logic [LA-1:0]           addr_q  [LFB_SZ];
    logic                    iss_valid_q;
    logic [OFFSET_BITS:0]    cnt_q;
    logic [WORDS-1:0][31:0]  line_q;
    logic                    fill_en_q;
    logic [ID-1:0]           fill_id_q;
    logic                    err_q;

    logic                    free_any, wi_any, miss_match, do_alloc;
    logic [ID-1:0]           alloc_id, wi_id;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        free_any    = 1'b0;
        alloc_id    = '0;
        wi_any      = 1'b0;
        wi_id       = '0;
        miss_match  = 1'b0;
        pending_hit = 1'b0;
        for (int i = LFB_SZ - 1; i >= 0; i--) begin
            if (state_q[i] == E_FREE) begin
                free_any = 1'b1;
                alloc_id = ID'(i);
            end
            if (state_q[i] == E_WAIT_ISSUE) begin
                wi_any = 1'b1;
                wi_id  = ID'(i);
            end
            if (state_q[i] != E_FREE && addr_q[i] == miss_addr)   miss_match  = 1'b1;
            if (state_q[i] != E_FREE && addr_q[i] == lookup_addr) pending_hit = 1'b1;
        end
    end

`ifdef L1D_REFILL_MERGE_EN
    assign miss_ready = free_any || miss_match;
    assign do_alloc   = miss_valid && free_any && !miss_match;
`else
    assign miss_ready = free_any;
    assign do_alloc   = miss_valid && free_any;
`endif

    // A fresh miss may go straight into an empty issue slot, but only when no older entry is waiting.
    logic           req_hs, iss_load;
    logic [ID-1:0]  iss_id;
    logic [LA-1:0]  iss_addr;
    assign req_hs   = iss_valid_q && mem_req_ready;
    assign iss_load = !iss_valid_q && (wi_any || do_alloc);
    assign iss_id   = wi_any ? wi_id : alloc_id;
    assign iss_addr = wi_any ? addr_q[wi_id] : miss_addr;

    logic resp_ok, beat_ok, beat_over, beat_write, beat_last, err_set;
    assign resp_ok    = state_q[mem_resp_id] == E_WAIT_RESP;
    assign beat_ok    = mem_resp_valid && resp_ok;
    assign beat_over  = cnt_q[OFFSET_BITS];
    assign beat_write = beat_ok && !beat_over;
    assign beat_last  = beat_ok && mem_resp_last;
    assign err_set    = (mem_resp_valid && !resp_ok)
                     || (beat_ok && beat_over && !mem_resp_last)
                     || (beat_last && (beat_over || !(&cnt_q[OFFSET_BITS-1:0])));

    always_comb begin
        for (int i = 0; i < LFB_SZ; i++) begin
            state_d[i] = state_q[i];
            if (do_alloc && alloc_id == ID'(i))     state_d[i] = E_WAIT_ISSUE;
            if (req_hs && mem_req_id == ID'(i))     state_d[i] = E_WAIT_RESP;
            if (beat_last && mem_resp_id == ID'(i)) state_d[i] = E_FILL;
            if (fill_en_q && fill_id_q == ID'(i))   state_d[i] = E_FREE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LFB_SZ; i++) begin
                state_q[i] <= E_FREE;
                addr_q[i]  <= '0;
            end
            iss_valid_q  <= 1'b0;
            mem_req_addr <= '0;
            mem_req_id   <= '0;
            cnt_q        <= '0;
            // NOTE: the line buffer is a handful of flops, not a RAM, so it is reset with everything else.
            line_q       <= '0;
            fill_en_q    <= 1'b0;
            fill_id_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < LFB_SZ; i++) state_q[i] <= state_d[i];
            if (do_alloc) addr_q[alloc_id] <= miss_addr;

            if (iss_valid_q) begin
                if (mem_req_ready) iss_valid_q <= 1'b0;
            end else if (iss_load) begin
                iss_valid_q  <= 1'b1;
                mem_req_addr <= iss_addr;
                mem_req_id   <= iss_id;
            end

            if (beat_write) line_q[cnt_q[OFFSET_BITS-1:0]] <= mem_resp_data;
            if (beat_last)       cnt_q <= '0;
            else if (beat_write) cnt_q <= cnt_q + 1'b1;

            fill_en_q <= beat_last;
            if (beat_last) fill_id_q <= mem_resp_id;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign mem_req_valid = iss_valid_q;
    assign fill_en       = fill_en_q;
    assign fill_set      = addr_q[fill_id_q][SET_BITS-1:0];
    assign fill_tag      = addr_q[fill_id_q][LA-1:SET_BITS];
    assign fill_line     = line_q;
    assign err           = err_q;

endmodule

// File: tb/tb_l1d_refill_ctrl.sv
// Self-checking bench for l1d_refill_ctrl: directed scenarios plus a randomized run against a
// queue-based model of in-flight lines. Honors L1D_REFILL_MERGE_EN when defined.
module tb_l1d_refill_ctrl;
    localparam int OFFSET_BITS = 2, SET_BITS = 5, ADDR_BITS = 30, LFB_SZ = 4;
    localparam int LA = ADDR_BITS - OFFSET_BITS, TAG_BITS = LA - SET_BITS, ID = 2, WORDS = 4;
`ifdef L1D_REFILL_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                miss_valid, miss_ready, pending_hit;
    logic [LA-1:0]       miss_addr, lookup_addr;
    logic                mem_req_valid, mem_req_ready;
    logic [LA-1:0]       mem_req_addr;
    logic [ID-1:0]       mem_req_id;
    logic                mem_resp_valid, mem_resp_last;
    logic [ID-1:0]       mem_resp_id;
    logic [31:0]         mem_resp_data;
    logic                fill_en, err;
    logic [SET_BITS-1:0] fill_set;
    logic [TAG_BITS-1:0] fill_tag;
    logic [32*WORDS-1:0] fill_line;

    int n_cmp = 0;
    int n_bad = 0;

    l1d_refill_ctrl #(.OFFSET_BITS(OFFSET_BITS), .SET_BITS(SET_BITS), .ADDR_BITS(ADDR_BITS), .LFB_SZ(LFB_SZ)) dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .lookup_addr(lookup_addr), .pending_hit(pending_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_id(mem_req_id),
        .mem_resp_valid(mem_resp_valid), .mem_resp_id(mem_resp_id),
        .mem_resp_data(mem_resp_data), .mem_resp_last(mem_resp_last),
        .fill_en(fill_en), .fill_set(fill_set), .fill_tag(fill_tag), .fill_line(fill_line),
        .err(err)
    );

    // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        miss_valid = 1'b0; miss_addr = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_id = '0; mem_resp_data = '0; mem_resp_last = 1'b0;
    endtask

    task automatic beat(input logic [ID-1:0] id, input logic [31:0] d, input logic last);
        mem_resp_valid = 1'b1; mem_resp_id = id; mem_resp_data = d; mem_resp_last = last;
        next_cycle();
        mem_resp_valid = 1'b0; mem_resp_last = 1'b0;
    endtask

    task automatic send_line(input logic [ID-1:0] id, input logic [32*WORDS-1:0] line);
        for (int k = 0; k < WORDS; k++) beat(id, line[k*32 +: 32], k == WORDS - 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        idle();
    endtask

    function automatic logic [32*WORDS-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1; idle(); lookup_addr = '0;
        repeat (2) next_cycle();
        #1;
        n_cmp++;
        if ({miss_ready, mem_req_valid, fill_en, err, pending_hit} !== 5'b10000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 10000", {miss_ready, mem_req_valid, fill_en, err, pending_hit});
        end
        n_cmp++;
        if ({mem_req_addr, mem_req_id, fill_set, fill_tag} !== '0 || fill_line !== '0) begin
            n_bad++; $display("FAIL reset_values: addr %h id %0d set %h tag %h line %h want all zero",
                              mem_req_addr, mem_req_id, fill_set, fill_tag, fill_line);
        end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_miss();
        logic [32*WORDS-1:0] line;
        line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        lookup_addr = 28'h0123; miss_valid = 1'b1; miss_addr = 28'h0123;
        #1;
        n_cmp++;
        if (miss_ready !== 1'b1 || pending_hit !== 1'b0) begin
            n_bad++; $display("FAIL single_accept: ready %b hit %b want 1 0", miss_ready, pending_hit);
        end
        next_cycle();
        miss_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        n_cmp++;
        if ({mem_req_valid, mem_req_id, mem_req_addr, pending_hit} !== {1'b1, 2'd0, 28'h0123, 1'b1}) begin
            n_bad++; $display("FAIL single_req: valid %b id %0d addr %h hit %b want 1 0 0123 1",
                              mem_req_valid, mem_req_id, mem_req_addr, pending_hit);
        end
        next_cycle();
        mem_req_ready = 1'b0;
        #1;
        n_cmp++;
        if (mem_req_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_req_drop: valid %b want 0", mem_req_valid);
        end
        send_line(2'd0, line);
        #1;
        n_cmp++;
        if ({fill_en, fill_set, fill_tag, fill_line, pending_hit} !== {1'b1, 5'h03, 23'h9, line, 1'b1}) begin
            n_bad++; $display("FAIL single_fill: en %b set %h tag %h line %h hit %b want 1 03 9 %h 1",
                              fill_en, fill_set, fill_tag, fill_line, pending_hit, line);
        end
        next_cycle();
        #1;
        n_cmp++;
        if ({fill_en, pending_hit, err} !== 3'b000) begin
            n_bad++; $display("FAIL single_after: en %b hit %b err %b want 000", fill_en, pending_hit, err);
        end
        next_cycle();
    endtask

    task automatic test_full_stall();
        logic [LA-1:0] a [4];
        logic [LA-1:0] a4;
        logic [ID-1:0] got_id [4];
        logic [LA-1:0] got_addr [4];
        logic [32*WORDS-1:0] line;
        int got_n;
        for (int i = 0; i < 4; i++) a[i] = {LA'($urandom) & ~LA'(7)} | LA'(i);
        a4 = {LA'($urandom) & ~LA'(7)} | LA'(4);
        for (int i = 0; i < 4; i++) begin
            miss_valid = 1'b1; miss_addr = a[i];
            #1;
            n_cmp++;
            if (miss_ready !== 1'b1) begin
                n_bad++; $display("FAIL full_accept%0d: ready %b want 1", i, miss_ready);
            end
            next_cycle();
        end
        miss_addr = a4;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_cmp++;
            if ({miss_ready, mem_req_valid, mem_req_id, mem_req_addr} !== {1'b0, 1'b1, 2'd0, a[0]}) begin
                n_bad++; $display("FAIL full_stall c%0d: ready %b valid %b id %0d addr %h want 0 1 0 %h",
                                  c, miss_ready, mem_req_valid, mem_req_id, mem_req_addr, a[0]);
            end
            next_cycle();
        end
        miss_valid = 1'b0; mem_req_ready = 1'b1; got_n = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (mem_req_valid && got_n < 4) begin
                got_id[got_n] = mem_req_id; got_addr[got_n] = mem_req_addr; got_n++;
            end
            next_cycle();
        end
        mem_req_ready = 1'b0;
        n_cmp++;
        if (got_n != 4) begin
            n_bad++; $display("FAIL full_issue_count: got %0d want 4", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            n_cmp++;
            if (got_id[i] !== ID'(i) || got_addr[i] !== a[i]) begin
                n_bad++; $display("FAIL full_order%0d: id %0d addr %h want %0d %h", i, got_id[i], got_addr[i], i, a[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            line = rand_line();
            send_line(ID'(i), line);
            #1;
            n_cmp++;
            if ({fill_en, fill_set, fill_tag, fill_line} !== {1'b1, a[i][SET_BITS-1:0], a[i][LA-1:SET_BITS], line}) begin
                n_bad++; $display("FAIL full_fill%0d: en %b set %h tag %h line %h want set %h tag %h line %h", i,
                                  fill_en, fill_set, fill_tag, fill_line, a[i][SET_BITS-1:0], a[i][LA-1:SET_BITS], line);
            end
        end
        next_cycle();
    endtask

    task automatic test_duplicate();
        logic [ID-1:0] got_id [4];
        logic [32*WORDS-1:0] line;
        int got_n, want_n;
        want_n = MERGE ? 1 : 2;
        got_n = 0;
        mem_req_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            miss_valid = (c < 2); miss_addr = 28'h0040;
            #1;
            if (c == 1) begin
                n_cmp++;
                if (miss_ready !== 1'b1) begin
                    n_bad++; $display("FAIL dup_second_ready: %b want 1", miss_ready);
                end
            end
            if (mem_req_valid && got_n < 4) begin
                n_cmp++;
                if (mem_req_addr !== 28'h0040) begin
                    n_bad++; $display("FAIL dup_req_addr: %h want 0040", mem_req_addr);
                end
                got_id[got_n] = mem_req_id; got_n++;
            end
            next_cycle();
        end
        idle();
        n_cmp++;
        if (got_n != want_n) begin
            n_bad++; $display("FAIL dup_req_count: got %0d want %0d", got_n, want_n);
        end
        for (int i = 0; i < got_n; i++) begin
            line = rand_line();
            send_line(got_id[i], line);
            #1;
            n_cmp++;
            if ({fill_en, fill_set, fill_tag, fill_line} !== {1'b1, 5'h00, 23'h2, line}) begin
                n_bad++; $display("FAIL dup_fill%0d: en %b set %h tag %h line %h want 1 00 2 %h",
                                  i, fill_en, fill_set, fill_tag, fill_line, line);
            end
        end
        next_cycle();
        #1;
        n_cmp++;
        if (fill_en !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL dup_after: en %b err %b want 0 0", fill_en, err);
        end
        next_cycle();
    endtask

    task automatic test_free_race_and_reset();
        logic [LA-1:0] b;
        b = 28'h0ABCDE5;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            miss_valid = 1'b1; miss_addr = 28'h0100000 + LA'(i * 32);
            next_cycle();
        end
        miss_valid = 1'b0;
        repeat (8) next_cycle();
        mem_req_ready = 1'b0;
        #1;
        n_cmp++;
        if (mem_req_valid !== 1'b0 || miss_ready !== 1'b0) begin
            n_bad++; $display("FAIL race_setup: valid %b ready %b want 0 0", mem_req_valid, miss_ready);
        end
        for (int k = 0; k < WORDS - 1; k++) beat(2'd0, 32'h55 + 32'(k), 1'b0);
        mem_resp_valid = 1'b1; mem_resp_id = 2'd0; mem_resp_data = 32'h58; mem_resp_last = 1'b1;
        miss_valid = 1'b1; miss_addr = b;
        #1;
        n_cmp++;
        if (miss_ready !== 1'b0) begin
            n_bad++; $display("FAIL race_last_cycle_ready: %b want 0", miss_ready);
        end
        next_cycle();
        mem_resp_valid = 1'b0; mem_resp_last = 1'b0;
        #1;
        n_cmp++;
        if (fill_en !== 1'b1 || miss_ready !== 1'b0) begin
            n_bad++; $display("FAIL race_fill_cycle: en %b ready %b want 1 0", fill_en, miss_ready);
        end
        next_cycle();
        #1;
        n_cmp++;
        if (fill_en !== 1'b0 || miss_ready !== 1'b1) begin
            n_bad++; $display("FAIL race_free_cycle: en %b ready %b want 0 1", fill_en, miss_ready);
        end
        next_cycle();
        miss_valid = 1'b0; lookup_addr = b;
        #1;
        n_cmp++;
        if ({mem_req_valid, mem_req_id, mem_req_addr} !== {1'b1, 2'd0, b}) begin
            n_bad++; $display("FAIL race_realloc: valid %b id %0d addr %h want 1 0 %h", mem_req_valid, mem_req_id, mem_req_addr, b);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({miss_ready, mem_req_valid, fill_en, err, pending_hit} !== 5'b10000
            || {mem_req_addr, mem_req_id, fill_set, fill_tag} !== '0 || fill_line !== '0) begin
            n_bad++; $display("FAIL async_reset: ready %b valid %b en %b err %b hit %b addr %h line %h want reset values",
                              miss_ready, mem_req_valid, fill_en, err, pending_hit, mem_req_addr, fill_line);
        end
        next_cycle();
        rst = 1'b0;
        beat(2'd1, 32'h1234, 1'b0);
        #1;
        n_cmp++;
        if (err !== 1'b1 || fill_en !== 1'b0) begin
            n_bad++; $display("FAIL stale_beat_err: err %b en %b want 1 0", err, fill_en);
        end
    endtask

    task automatic test_bad_id();
        pulse_reset();
        #1;
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL badid_pre: err %b want 0", err);
        end
        beat(2'd2, 32'hDEAD, 1'b1);
        #1;
        n_cmp++;
        if (err !== 1'b1 || fill_en !== 1'b0) begin
            n_bad++; $display("FAIL badid_err: err %b en %b want 1 0", err, fill_en);
        end
        repeat (3) next_cycle();
        #1;
        n_cmp++;
        if (err !== 1'b1 || fill_en !== 1'b0) begin
            n_bad++; $display("FAIL badid_sticky: err %b en %b want 1 0", err, fill_en);
        end
    endtask

    task automatic issue_one(input logic [LA-1:0] a);
        miss_valid = 1'b1; miss_addr = a;
        next_cycle();
        miss_valid = 1'b0; mem_req_ready = 1'b1;
        next_cycle();
        mem_req_ready = 1'b0;
    endtask

    task automatic test_short_line();
        pulse_reset();
        issue_one(28'h0555);
        beat(2'd0, 32'hD0, 1'b0);
        beat(2'd0, 32'hD1, 1'b1);
        #1;
        n_cmp++;
        if ({fill_en, err, fill_line} !== {1'b1, 1'b1, 32'h0, 32'h0, 32'hD1, 32'hD0}) begin
            n_bad++; $display("FAIL short_fill: en %b err %b line %h want 1 1 with words D0 D1 then zeros", fill_en, err, fill_line);
        end
        next_cycle();
    endtask

    task automatic test_overlong_line();
        pulse_reset();
        issue_one(28'h0777);
        for (int k = 0; k < WORDS + 1; k++) beat(2'd0, 32'hE0 + 32'(k), 1'b0);
        #1;
        n_cmp++;
        if (err !== 1'b1 || fill_en !== 1'b0) begin
            n_bad++; $display("FAIL overlong_err: err %b en %b want 1 0", err, fill_en);
        end
        beat(2'd0, 32'hEF, 1'b1);
        #1;
        n_cmp++;
        if ({fill_en, fill_line} !== {1'b1, 32'hE3, 32'hE2, 32'hE1, 32'hE0}) begin
            n_bad++; $display("FAIL overlong_fill: en %b line %h want 1 000000e3000000e2000000e1000000e0", fill_en, fill_line);
        end
        next_cycle();
    endtask

    task automatic test_random(input int n_cycles);
        logic [LA-1:0]       pool [6];
        logic [LA-1:0]       inflight [$];
        logic [LA-1:0]       unissued [$];
        logic [LA-1:0]       ef_addr [$];
        logic [32*WORDS-1:0] ef_line [$];
        logic [LA-1:0]       id_addr [LFB_SZ];
        bit                  id_busy [LFB_SZ];
        int                  rq [$];
        bit                  exp_fill, sending, prev_stall, found, exp_hit, exp_match, exp_ready, allow;
        int                  cur_id, beat_k;
        logic [32*WORDS-1:0] cur_line, ln;
        logic [LA-1:0]       prev_addr, ea;
        logic [ID-1:0]       prev_id;
        pulse_reset();
        for (int i = 0; i < 6; i++) pool[i] = LA'($urandom);
        for (int i = 0; i < LFB_SZ; i++) id_busy[i] = 1'b0;
        exp_fill = 1'b0; sending = 1'b0; prev_stall = 1'b0;
        cur_id = 0; beat_k = 0; cur_line = '0; prev_addr = '0; prev_id = '0;
        for (int cyc = 0; cyc < n_cycles + 400; cyc++) begin
            allow = (cyc < n_cycles);
            if (!allow && inflight.size() == 0 && !sending && rq.size() == 0 && !exp_fill) break;
            miss_valid    = allow && ($urandom_range(0, 2) == 0);
            miss_addr     = pool[$urandom_range(0, 5)];
            lookup_addr   = pool[$urandom_range(0, 5)];
            mem_req_ready = !allow || ($urandom_range(0, 1) == 1);
            if (!sending && rq.size() > 0 && $urandom_range(0, 2) != 0) begin
                sending = 1'b1; cur_id = rq.pop_front(); beat_k = 0; cur_line = rand_line();
            end
            mem_resp_valid = sending;
            mem_resp_id    = ID'(cur_id);
            mem_resp_data  = cur_line[beat_k*32 +: 32];
            mem_resp_last  = sending && (beat_k == WORDS - 1);
            #1;
            exp_hit = 1'b0; exp_match = 1'b0;
            foreach (inflight[j]) begin
                if (inflight[j] == lookup_addr) exp_hit = 1'b1;
                if (inflight[j] == miss_addr)   exp_match = 1'b1;
            end
            exp_ready = (inflight.size() < LFB_SZ) || (MERGE && exp_match);
            n_cmp++;
            if (pending_hit !== exp_hit || miss_ready !== exp_ready || fill_en !== exp_fill) begin
                n_bad++; $display("FAIL rand_ctl cyc%0d: hit %b ready %b en %b want %b %b %b",
                                  cyc, pending_hit, miss_ready, fill_en, exp_hit, exp_ready, exp_fill);
            end
            if (exp_fill && ef_addr.size() > 0) begin
                ea = ef_addr.pop_front(); ln = ef_line.pop_front();
                n_cmp++;
                if ({fill_set, fill_tag, fill_line} !== {ea[SET_BITS-1:0], ea[LA-1:SET_BITS], ln}) begin
                    n_bad++; $display("FAIL rand_fill cyc%0d: set %h tag %h line %h want %h %h %h", cyc,
                                      fill_set, fill_tag, fill_line, ea[SET_BITS-1:0], ea[LA-1:SET_BITS], ln);
                end
                for (int j = 0; j < inflight.size(); j++) if (inflight[j] == ea) begin inflight.delete(j); break; end
            end
            if (prev_stall) begin
                n_cmp++;
                if (mem_req_valid !== 1'b1 || mem_req_id !== prev_id || mem_req_addr !== prev_addr) begin
                    n_bad++; $display("FAIL rand_req_hold cyc%0d: valid %b id %0d addr %h want 1 %0d %h",
                                      cyc, mem_req_valid, mem_req_id, mem_req_addr, prev_id, prev_addr);
                end
            end
            if (mem_req_valid === 1'b1 && mem_req_ready) begin
                found = 1'b0;
                for (int j = 0; j < unissued.size(); j++) if (unissued[j] == mem_req_addr) begin
                    unissued.delete(j); found = 1'b1; break;
                end
                n_cmp++;
                if (!found || id_busy[mem_req_id]) begin
                    n_bad++; $display("FAIL rand_req cyc%0d: addr %h id %0d expected-addr %b id-free %b want 1 1",
                                      cyc, mem_req_addr, mem_req_id, found, !id_busy[mem_req_id]);
                end
                id_busy[mem_req_id] = 1'b1; id_addr[mem_req_id] = mem_req_addr; rq.push_back(int'(mem_req_id));
            end
            prev_stall = (mem_req_valid === 1'b1) && !mem_req_ready;
            prev_addr = mem_req_addr; prev_id = mem_req_id;
            if (miss_valid && exp_ready && !(MERGE && exp_match)) begin
                inflight.push_back(miss_addr); unissued.push_back(miss_addr);
            end
            exp_fill = 1'b0;
            if (sending) begin
                if (beat_k == WORDS - 1) begin
                    ef_addr.push_back(id_addr[cur_id]); ef_line.push_back(cur_line);
                    exp_fill = 1'b1; id_busy[cur_id] = 1'b0; sending = 1'b0;
                end else begin
                    beat_k++;
                end
            end
            next_cycle();
        end
        idle();
        #1;
        n_cmp++;
        if (inflight.size() != 0 || err !== 1'b0) begin
            n_bad++; $display("FAIL rand_drain: %0d lines still in flight, err %b, want 0 0", inflight.size(), err);
        end
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_full_stall();
        test_duplicate();
        test_free_race_and_reset();
        test_bad_id();
        test_short_line();
        test_overlong_line();
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
